// File: rtl/pipe_share_arb_pkg.sv
// rtl/pipe_share_arb_pkg.sv - shared types and helpers for the pipeline-sharing arbiter
package pipe_share_arb_pkg;

    localparam int MAX_REQ  = 16;
    localparam int MAX_ID_W = 4;

    typedef logic [MAX_REQ-1:0]  req_vec_t;
    typedef logic [MAX_ID_W-1:0] idx_t;

    function automatic int id_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 5; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic idx_t encode(input req_vec_t oh);
        idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx_t'(i);
        end
        return idx;
    endfunction

    // Returns {found, index} of the first set candidate at or above ptr, wrapping at n.
    function automatic logic [MAX_ID_W:0] rr_search(input req_vec_t cand, input idx_t ptr, input int n);
        logic [MAX_ID_W:0] res;
        int j;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (k < n && !res[MAX_ID_W] && cand[j[3:0]]) res = {1'b1, idx_t'(j)};
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_share_arb_tag_delay.sv
// rtl/pipe_share_arb_tag_delay.sv - enable-gated tag shift register tracking the external pipeline
module pipe_tag_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/pipe_share_arb.sv
// rtl/pipe_share_arb.sv - round-robin sharing of one enable-stalled fixed-latency pipeline
module pipe_share_arb
    import pipe_share_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int LATENCY    = 2,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_en,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          pipe_en,
    output logic [DATA_WIDTH-1:0]         pipe_din,
    input  logic [OUT_WIDTH-1:0]          pipe_dout,
    output logic                          dout_valid,
    output logic [ID_W-1:0]               dout_id,
    output logic [OUT_WIDTH-1:0]          dout,
    input  logic                          dout_ready
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic                  adv;
    logic [ID_W-1:0]       ptr;
    logic [MAX_ID_W:0]     srch;
    logic                  hit;
    logic [MAX_ID_W-1:0]   sel_idx;
    logic                  any_gnt;
    logic [ID_W-1:0]       gnt_id;

    assign srch    = rr_search(req_vec_t'(req & req_en), idx_t'(ptr), NUM_REQ);
    assign hit     = srch[MAX_ID_W];
    assign sel_idx = srch[MAX_ID_W-1:0];

    assign gnt     = (adv && hit) ? (NUM_REQ'(1) << sel_idx) : '0;
    assign any_gnt = |gnt;
    assign gnt_id  = ID_W'(encode(req_vec_t'(gnt)));
    assign pipe_en = adv;
    assign dout    = pipe_dout;

    always_comb begin
        pipe_din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) pipe_din = din[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (any_gnt) begin
            ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
        end
    end

    // Without tag stages the result is the grant itself, so advancing hinges on dout_ready alone.
    generate
        if (LATENCY == 0) begin : g_lat0
            assign adv        = dout_ready;
            assign dout_valid = any_gnt;
            assign dout_id    = gnt_id;
        end else begin : g_latn
            logic [ID_W:0] tag_q;

            assign adv = ~dout_valid | dout_ready;

            pipe_tag_delay #(
                .WIDTH (ID_W + 1),
                .DEPTH (LATENCY)
            ) u_tag (
                .clk (clk),
                .rst (rst),
                .en  (adv),
                .d   ({any_gnt, gnt_id}),
                .q   (tag_q)
            );

            assign dout_valid = tag_q[ID_W];
            assign dout_id    = tag_q[ID_W-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_pipe_share_arb.sv
// tb/tb_pipe_share_arb.sv - directed bench for pipe_share_arb at LATENCY 2 and 0
module tb_pipe_share_arb;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int OW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     req_en = '1;
    logic [NR*DW-1:0]  din = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    logic              dout_ready = 1'b1;
    logic              dout_ready0 = 1'b1;

    logic [NR-1:0] gnt, gnt0;
    logic          pipe_en, pipe_en0;
    logic [DW-1:0] pipe_din, pipe_din0;
    logic [OW-1:0] pipe_dout, pipe_dout0, dout, dout0;
    logic          dout_valid, dout_valid0;
    logic [1:0]    dout_id, dout_id0;

    // Two-stage external pipeline that adds one, frozen when pipe_en is low.
    logic [DW-1:0] p1 = '0, p2 = '0;
    always @(posedge clk) if (pipe_en) begin
        p1 <= pipe_din;
        p2 <= p1;
    end
    assign pipe_dout  = p2 + 16'd1;
    assign pipe_dout0 = pipe_din0 + 16'd1;

    pipe_share_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_en(req_en), .din(din),
        .gnt(gnt), .pipe_en(pipe_en), .pipe_din(pipe_din), .pipe_dout(pipe_dout),
        .dout_valid(dout_valid), .dout_id(dout_id), .dout(dout), .dout_ready(dout_ready)
    );

    pipe_share_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .req_en(req_en), .din(din),
        .gnt(gnt0), .pipe_en(pipe_en0), .pipe_din(pipe_din0), .pipe_dout(pipe_dout0),
        .dout_valid(dout_valid0), .dout_id(dout_id0), .dout(dout0), .dout_ready(dout_ready0)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        req_en = '1;
        dout_ready = 1'b1;
        dout_ready0 = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        #2;
        vectors++;
        if (dout_valid !== 1'b0 || dout_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_tag got v=%b id=%0d want v=0 id=0", dout_valid, dout_id);
        end
        vectors++;
        if (pipe_en !== 1'b1 || gnt !== 4'b0001 || pipe_din !== 16'h1111) begin
            miscompares++;
            $display("FAIL reset_comb got en=%b gnt=%b din=%h want en=1 gnt=0001 din=1111", pipe_en, gnt, pipe_din);
        end
        req = '0;
        #1;
        vectors++;
        if (gnt !== 4'b0000 || pipe_din !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_idle got gnt=%b din=%h want 0000/0000", gnt, pipe_din);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  e_g;
        logic [1:0]  e_id;
        logic [15:0] e_d;
        do_reset();
        req = 4'b1111;
        #1;
        for (int c = 0; c < 7; c++) begin
            e_g = 4'b0001 << (c % 4);
            vectors++;
            if (gnt !== e_g) begin
                miscompares++;
                $display("FAIL rr_gnt c=%0d got %b want %b", c, gnt, e_g);
            end
            vectors++;
            if (dout_valid !== (c >= 2)) begin
                miscompares++;
                $display("FAIL rr_valid c=%0d got %b want %b", c, dout_valid, (c >= 2));
            end
            if (c >= 2) begin
                e_id = 2'((c - 2) % 4);
                e_d  = 16'(16'h1111 * (((c - 2) % 4) + 1) + 1);
                vectors++;
                if (dout_id !== e_id || dout !== e_d) begin
                    miscompares++;
                    $display("FAIL rr_out c=%0d got id=%0d d=%h want id=%0d d=%h", c, dout_id, dout, e_id, e_d);
                end
            end
            tick();
        end
    endtask

    task automatic test_sparse_req();
        logic [3:0] e_g [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        do_reset();
        req = 4'b1010;
        #1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (gnt !== e_g[c]) begin
                miscompares++;
                $display("FAIL sparse_gnt c=%0d got %b want %b", c, gnt, e_g[c]);
            end
            tick();
        end
    endtask

    task automatic test_req_en_mask();
        logic [3:0] e_g [5] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
        do_reset();
        req = 4'b1111;
        req_en = 4'b1101;
        #1;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (gnt !== e_g[c]) begin
                miscompares++;
                $display("FAIL mask_gnt c=%0d got %b want %b", c, gnt, e_g[c]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [3:0]  e_g;
        logic [1:0]  e_id;
        logic [15:0] e_d;
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        tick();
        dout_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (pipe_en !== 1'b0 || gnt !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall_en c=%0d got en=%b gnt=%b want en=0 gnt=0000", c, pipe_en, gnt);
            end
            vectors++;
            if (dout_valid !== 1'b1 || dout_id !== 2'd1 || dout !== 16'h2223) begin
                miscompares++;
                $display("FAIL stall_hold c=%0d got v=%b id=%0d d=%h want v=1 id=1 d=2223", c, dout_valid, dout_id, dout);
            end
            tick();
        end
        dout_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            e_g  = 4'b0001 << ((3 + k) % 4);
            e_id = 2'((1 + k) % 4);
            e_d  = 16'(16'h1111 * (((1 + k) % 4) + 1) + 1);
            vectors++;
            if (pipe_en !== 1'b1 || gnt !== e_g) begin
                miscompares++;
                $display("FAIL resume_gnt k=%0d got en=%b gnt=%b want en=1 gnt=%b", k, pipe_en, gnt, e_g);
            end
            vectors++;
            if (dout_valid !== 1'b1 || dout_id !== e_id || dout !== e_d) begin
                miscompares++;
                $display("FAIL resume_out k=%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h", k, dout_valid, dout_id, dout, e_id, e_d);
            end
            tick();
        end
    endtask

    task automatic test_latency0();
        do_reset();
        req = 4'b1111;
        dout_ready0 = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (gnt0 !== 4'b0000 || dout_valid0 !== 1'b0 || pipe_en0 !== 1'b0) begin
                miscompares++;
                $display("FAIL lat0_stall c=%0d got gnt=%b v=%b en=%b want 0000/0/0", c, gnt0, dout_valid0, pipe_en0);
            end
            tick();
        end
        dout_ready0 = 1'b1;
        #1;
        vectors++;
        if (gnt0 !== 4'b0001 || dout_valid0 !== 1'b1 || dout_id0 !== 2'd0 || dout0 !== 16'h1112) begin
            miscompares++;
            $display("FAIL lat0_first got gnt=%b v=%b id=%0d d=%h want 0001/1/0/1112", gnt0, dout_valid0, dout_id0, dout0);
        end
        tick();
        vectors++;
        if (gnt0 !== 4'b0010 || dout_valid0 !== 1'b1 || dout_id0 !== 2'd1 || dout0 !== 16'h2223) begin
            miscompares++;
            $display("FAIL lat0_next got gnt=%b v=%b id=%0d d=%h want 0010/1/1/2223", gnt0, dout_valid0, dout_id0, dout0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        vectors++;
        if (dout_valid !== 1'b1 || dout_id !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_pre got v=%b id=%0d want v=1 id=0", dout_valid, dout_id);
        end
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (dout_valid !== 1'b0 || dout_id !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_async got v=%b id=%0d want v=0 id=0", dout_valid, dout_id);
        end
        req = 4'b1110;
        req_en = 4'b1011;
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL mid_first got gnt=%b want 0010", gnt);
        end
        tick();
        vectors++;
        if (gnt !== 4'b1000 || dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_second got gnt=%b v=%b want 1000/0", gnt, dout_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_sparse_req();
        test_req_en_mask();
        test_stall();
        test_latency0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
